// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, signed range helpers and sub encoding for the DSP MAC slice
package dsp_pkg;
   localparam int DEF_AW = 18;
   localparam int DEF_BW = 18;
   localparam int DEF_PW = 48;
   localparam int DEF_LW = 8;
   localparam logic SUB_ADD = 1'b0;
   localparam logic SUB_SUB = 1'b1;
   function automatic logic [127:0] smax(input int w);
      return (128'(1) << (w - 1)) - 128'(1);
   endfunction
   function automatic logic [127:0] smin(input int w);
      return ~smax(w);
   endfunction
endpackage

// File: rtl/dsp_sat_add.sv
// dsp_sat_add: PW+1-bit signed add of accumulator base and product with overflow detect and optional saturation
module dsp_sat_add
   import dsp_pkg::*;
#(
   parameter int PW  = DEF_PW,
   parameter int MW  = DEF_AW + DEF_BW + 1,
   parameter int SAT = 1
) (
   input  logic [PW-1:0] base,
   input  logic [MW-1:0] m,
   output logic [PW-1:0] res,
   output logic          ovf
);
   localparam logic [PW-1:0] MAXV = PW'(smax(PW));
   localparam logic [PW-1:0] MINV = PW'(smin(PW));
   logic [PW:0] sum;
   always_comb begin
      sum = {base[PW-1], base} + {{(PW + 1 - MW){m[MW-1]}}, m};
      ovf = sum[PW] ^ sum[PW-1];
      res = (SAT != 0 && ovf) ? (m[MW-1] ? MINV : MAXV) : sum[PW-1:0];
   end
endmodule

// File: rtl/dsp_mac_accum.sv
// dsp_mac_accum: pipelined (D +/- B) x A multiply-accumulate over programmable-length frames
module dsp_mac_accum
   import dsp_pkg::*;
#(
   parameter int AW     = DEF_AW,
   parameter int BW     = DEF_BW,
   parameter int PW     = DEF_PW,
   parameter int LW     = DEF_LW,
   parameter int PREADD = 1,
   parameter int SAT    = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   input  logic [BW-1:0] d,
   input  logic          sub,
   input  logic [PW-1:0] c,
   input  logic [LW-1:0] acc_len,
   output logic [PW-1:0] p,
   output logic [PW-1:0] pcout,
   output logic          out_valid,
   output logic          ovf,
   output logic          busy
);
   localparam int MW = AW + BW + 1;
   logic [LW-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
   logic          first, last;
   logic          s1_valid_q, s1_valid_d, s1_sub_q, s1_sub_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic [AW-1:0] s1_a_q, s1_a_d;
   logic [BW-1:0] s1_b_q, s1_b_d, s1_d_q, s1_d_d;
   logic [PW-1:0] s1_c_q, s1_c_d;
   logic          s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
   logic [BW:0]   s2_pre_q, s2_pre_d;
   logic [AW-1:0] s2_a_q, s2_a_d;
   logic [PW-1:0] s2_c_q, s2_c_d;
   logic          s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
   logic [MW-1:0] s3_m_q, s3_m_d;
   logic [PW-1:0] s3_c_q, s3_c_d;
   logic [PW-1:0] p_q, p_d, base, sum_res;
   logic          ovf_q, ovf_d, out_valid_q, out_valid_d, sum_ovf;
   logic [BW:0]   d_ext, b_ext;
   always_comb begin
      first       = cnt_q == '0;
      len_eff     = first ? ((acc_len == '0) ? LW'(1) : acc_len) : len_q;
      last        = cnt_q == len_eff - LW'(1);
      cnt_d       = in_valid ? (last ? '0 : cnt_q + LW'(1)) : cnt_q;
      len_d       = (in_valid && first) ? len_eff : len_q;
      s1_valid_d  = in_valid;
      s1_a_d      = a;
      s1_b_d      = b;
      s1_d_d      = d;
      s1_sub_d    = sub;
      s1_first_d  = first;
      s1_last_d   = last;
      // the frame offset travels with its first sample, so later samples never disturb it
      s1_c_d      = (in_valid && first) ? c : s1_c_q;
      d_ext       = {s1_d_q[BW-1], s1_d_q};
      b_ext       = {s1_b_q[BW-1], s1_b_q};
      s2_valid_d  = s1_valid_q;
      s2_first_d  = s1_first_q;
      s2_last_d   = s1_last_q;
      s2_pre_d    = (PREADD == 0) ? b_ext : (s1_sub_q == SUB_ADD ? d_ext + b_ext : d_ext - b_ext);
      s2_a_d      = s1_a_q;
      s2_c_d      = s1_c_q;
      s3_valid_d  = s2_valid_q;
      s3_first_d  = s2_first_q;
      s3_last_d   = s2_last_q;
      s3_m_d      = MW'($signed(s2_pre_q)) * MW'($signed(s2_a_q));
      s3_c_d      = s2_c_q;
      base        = s3_first_q ? s3_c_q : p_q;
      p_d         = s3_valid_q ? sum_res : p_q;
      ovf_d       = s3_valid_q ? (sum_ovf | (ovf_q & ~s3_first_q)) : ovf_q;
      out_valid_d = s3_valid_q & s3_last_q;
   end
   dsp_sat_add #(.PW(PW), .MW(MW), .SAT(SAT)) u_sat_add (
      .base (base),
      .m    (s3_m_q),
      .res  (sum_res),
      .ovf  (sum_ovf)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         len_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_d_q      <= '0;
         s1_sub_q    <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_c_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_pre_q    <= '0;
         s2_a_q      <= '0;
         s2_c_q      <= '0;
         s3_valid_q  <= 1'b0;
         s3_first_q  <= 1'b0;
         s3_last_q   <= 1'b0;
         s3_m_q      <= '0;
         s3_c_q      <= '0;
         p_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_d_q      <= s1_d_d;
         s1_sub_q    <= s1_sub_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s1_c_q      <= s1_c_d;
         s2_valid_q  <= s2_valid_d;
         s2_first_q  <= s2_first_d;
         s2_last_q   <= s2_last_d;
         s2_pre_q    <= s2_pre_d;
         s2_a_q      <= s2_a_d;
         s2_c_q      <= s2_c_d;
         s3_valid_q  <= s3_valid_d;
         s3_first_q  <= s3_first_d;
         s3_last_q   <= s3_last_d;
         s3_m_q      <= s3_m_d;
         s3_c_q      <= s3_c_d;
         p_q         <= p_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign p         = p_q;
   assign pcout     = p_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;
   assign busy      = (cnt_q != '0) || s1_valid_q || s2_valid_q || s3_valid_q;
endmodule

// File: tb/tb_dsp_mac_accum.sv
// tb_dsp_mac_accum: directed frames on three parameter variants, checked against a frame-level arithmetic model
module tb_dsp_mac_accum;
   import dsp_pkg::*;
   localparam int AW = 18, BW = 18, PW = 48, LW = 8;
   localparam longint MAXP = 64'sh0000_7FFF_FFFF_FFFF;
   localparam longint MINP = -MAXP - 1;
   localparam longint WRAP = 64'sh0001_0000_0000_0000;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0;
   logic [AW-1:0] a = '0;
   logic [BW-1:0] b = '0, d = '0;
   logic [PW-1:0] c = '0;
   logic [LW-1:0] acc_len = '0;
   logic [PW-1:0] p_o[3], pc_o[3];
   logic ov_o[3], ovf_o[3], busy_o[3];
   int total = 0, bad = 0;
   logic chk_on = 1'b0;
   longint macc[3];
   logic movf[3];
   int mcnt, mlen;
   longint hp[4][3];
   logic hovf[4][3];
   logic hov[4];
   longint qp[3][$];
   logic qo[3][$];
   always #5 clk = ~clk;
   dsp_mac_accum #(.AW(AW), .BW(BW), .PW(PW), .LW(LW), .PREADD(1), .SAT(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .d(d), .sub(sub), .c(c), .acc_len(acc_len),
      .p(p_o[0]), .pcout(pc_o[0]), .out_valid(ov_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0]));
   dsp_mac_accum #(.AW(AW), .BW(BW), .PW(PW), .LW(LW), .PREADD(0), .SAT(1)) u_np (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .d(d), .sub(sub), .c(c), .acc_len(acc_len),
      .p(p_o[1]), .pcout(pc_o[1]), .out_valid(ov_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1]));
   dsp_mac_accum #(.AW(AW), .BW(BW), .PW(PW), .LW(LW), .PREADD(1), .SAT(0)) u_ns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .d(d), .sub(sub), .c(c), .acc_len(acc_len),
      .p(p_o[2]), .pcout(pc_o[2]), .out_valid(ov_o[2]), .ovf(ovf_o[2]), .busy(busy_o[2]));
   task automatic chk(input string nm, input int k, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0d, want %0d at %0t", nm, k, act, exp, $time);
      end
   endtask
   // model: per config k, 0 = pre-adder+saturate, 1 = B only+saturate, 2 = pre-adder+wrap
   always @(posedge clk) begin
      longint sa, sb, sd, sc, pre, m, base, s;
      logic o, lst;
      if (rst) begin
         mcnt = 0;
         mlen = 1;
         for (int k = 0; k < 3; k++) begin
            macc[k] = 0;
            movf[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
               hp[i][k] = 0;
               hovf[i][k] = 1'b0;
            end
         end
         for (int i = 0; i < 4; i++) hov[i] = 1'b0;
      end else begin
         lst = 1'b0;
         if (in_valid) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sd = longint'($signed(d));
            sc = longint'($signed(c));
            if (mcnt == 0) mlen = (acc_len == 0) ? 1 : int'(acc_len);
            for (int k = 0; k < 3; k++) begin
               pre = (k == 1) ? sb : (sub == SUB_SUB ? sd - sb : sd + sb);
               m = pre * sa;
               base = (mcnt == 0) ? sc : macc[k];
               s = base + m;
               o = (s > MAXP) || (s < MINP);
               if (!o) macc[k] = s;
               else if (k == 2) macc[k] = (s > MAXP) ? s - WRAP : s + WRAP;
               else macc[k] = (m >= 0) ? MAXP : MINP;
               movf[k] = (mcnt == 0) ? o : (movf[k] | o);
            end
            mcnt++;
            if (mcnt == mlen) begin
               mcnt = 0;
               lst = 1'b1;
            end
         end
         for (int i = 3; i > 0; i--) begin
            hov[i] = hov[i-1];
            for (int k = 0; k < 3; k++) begin
               hp[i][k] = hp[i-1][k];
               hovf[i][k] = hovf[i-1][k];
            end
         end
         hov[0] = lst;
         for (int k = 0; k < 3; k++) begin
            hp[0][k] = macc[k];
            hovf[0][k] = movf[k];
         end
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 3; k++) begin
            chk("p", k, longint'($signed(p_o[k])), hp[3][k]);
            chk("pcout", k, longint'($signed(pc_o[k])), hp[3][k]);
            chk("out_valid", k, longint'(ov_o[k]), longint'(hov[3]));
            if (hov[3]) chk("ovf", k, longint'(ovf_o[k]), longint'(hovf[3][k]));
            if (ov_o[k]) begin
               qp[k].push_back(longint'($signed(p_o[k])));
               qo[k].push_back(ovf_o[k]);
            end
         end
      end
   end
   task automatic smp(input longint va, input longint vb, input longint vd, input logic vs, input longint vc, input int vl);
      @(negedge clk);
      in_valid = 1'b1;
      a = va[AW-1:0];
      b = vb[BW-1:0];
      d = vd[BW-1:0];
      sub = vs;
      c = vc[PW-1:0];
      acc_len = vl[LW-1:0];
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask
   initial begin
      longint exp_p[3][11];
      logic exp_o[11];
      exp_p[0] = '{30, 10, 6, -94, MAXP, 1, 10, 1, MINP, 2, MAXP - 1};
      exp_p[1] = '{18, 10, 6, -121, MAXP, 1, 10, 1, MINP, 2, MAXP - 1};
      exp_p[2] = '{30, 10, 6, -94, MINP, 1, 10, 1, MAXP, 2, MAXP};
      exp_o = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_p", k, longint'($signed(p_o[k])), 0);
         chk("reset_ov", k, longint'(ov_o[k]), 0);
         chk("reset_ovf", k, longint'(ovf_o[k]), 0);
         chk("reset_busy", k, longint'(busy_o[k]), 0);
      end
      chk_on = 1'b1;
      rst = 1'b0;
      smp(4, 2, 3, 0, 10, 1);
      idle(8);
      for (int i = 1; i <= 4; i++) smp(i, 1, 0, 0, 0, 4);
      smp(1, 1, 0, 0, 5, 1);
      idle(8);
      smp(-3, 7, 5, 1, -100, 1);
      idle(8);
      smp(1, 1, 0, 0, MAXP, 1);
      smp(1, 1, 0, 0, 0, 1);
      idle(8);
      smp(2, 1, 0, 0, 1, 3);
      idle(2);
      smp(3, 1, 0, 0, 99, 1);
      idle(2);
      smp(4, 1, 0, 0, 99, 1);
      idle(8);
      smp(5, 1, 0, 0, 7, 4);
      smp(6, 1, 0, 0, 7, 4);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      smp(1, 1, 0, 0, 0, 1);
      idle(8);
      smp(-1, 1, 0, 0, MINP, 1);
      idle(8);
      smp(2, 1, 0, 0, 0, 0);
      idle(8);
      smp(1, 1, 0, 0, MAXP, 2);
      smp(-1, 1, 0, 0, 0, 2);
      idle(8);
      for (int k = 0; k < 3; k++) begin
         chk("pulse_count", k, longint'(qp[k].size()), 11);
         for (int i = 0; i < 11 && i < qp[k].size(); i++) begin
            chk($sformatf("frame%0d_p", i), k, qp[k][i], exp_p[k][i]);
            chk($sformatf("frame%0d_ovf", i), k, longint'(qo[k][i]), longint'(exp_o[i]));
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
